// File: rtl/hex_display_scanner.sv
// Time-multiplexes a 16-bit value onto a shared 7-segment decoder, one hex digit per slot.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module hex_display_scanner #(
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic        Load,
    input  logic [15:0] Value,
    output logic        Busy,
    output logic [3:0]  Dig_n,
    output logic        Z,
    output logic        Y,
    output logic        X,
    output logic        W,
    output logic        O,
    output logic        Frame
);

    localparam int CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF,
        DEAD,
        SHOW
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    index;
    logic [15:0]   shown;
    logic [15:0]   pending;
    logic          lead_blank;
    logic          frame_end;
    logic          transfer;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lead_blank = 1'b0;
        case (index)
            2'd3:    lead_blank = (shown[15:12] == 4'h0);
            2'd2:    lead_blank = (shown[15:8] == 8'h00);
            2'd1:    lead_blank = (shown[15:4] == 12'h000);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    assign lead_blank = 1'b0;
`endif

    // A new value only replaces the shown one between frames, so no frame ever mixes two values.
    assign frame_end = (state == SHOW) && Enable && (index == 2'd3) && (count == SHOW_LAST);
    assign transfer  = Busy && ((state == OFF) || frame_end);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state        <= OFF;
            count        <= '0;
            index        <= 2'd0;
            shown        <= 16'h0000;
            pending      <= 16'h0000;
            Busy         <= 1'b0;
            Dig_n        <= 4'b1111;
            {Z, Y, X, W} <= 4'h0;
            O            <= 1'b0;
            Frame        <= 1'b0;
        end else begin
            Dig_n        <= (state == SHOW) ? ~(4'b0001 << index) : 4'b1111;
            {Z, Y, X, W} <= (state == SHOW) ? shown[{index, 2'b00} +: 4] : 4'h0;
            O            <= (state == SHOW) && !lead_blank;
            Frame        <= frame_end;

            if (transfer) begin
                shown <= pending;
            end
            // A load in the transfer cycle still wins: the new value waits for the next boundary.
            if (Load) begin
                pending <= Value;
                Busy    <= 1'b1;
            end else if (transfer) begin
                Busy    <= 1'b0;
            end

            case (state)
                OFF: begin
                    count <= '0;
                    index <= 2'd0;
                    if (Enable) begin
                        state <= DEAD;
                    end
                end
                DEAD: begin
                    if (!Enable) begin
                        state <= OFF;
                        count <= '0;
                        index <= 2'd0;
                    end else if (count == DEAD_LAST) begin
                        count <= '0;
                        state <= SHOW;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                SHOW: begin
                    if (!Enable) begin
                        state <= OFF;
                        count <= '0;
                        index <= 2'd0;
                    end else if (count == SHOW_LAST) begin
                        count <= '0;
                        index <= index + 1'b1;
                        state <= DEAD;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= OFF;
                    count <= '0;
                    index <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: stimulus queues expected digit slots, a monitor checks them.
module tb_hex_display_scanner;

    localparam int P         = 4;
    localparam int D         = 2;
    localparam int FRAME_LEN = 4 * (P + D);
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        Clock;
    logic        Resetn;
    logic        Enable;
    logic        Load;
    logic [15:0] Value;
    logic        Busy;
    logic [3:0]  Dig_n;
    logic        Z, Y, X, W, O, Frame;

    hex_display_scanner #(.PRESCALE(P), .DEAD_CYCLES(D)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Enable(Enable),
        .Load  (Load),
        .Value (Value),
        .Busy  (Busy),
        .Dig_n (Dig_n),
        .Z     (Z),
        .Y     (Y),
        .X     (X),
        .W     (W),
        .O     (O),
        .Frame (Frame)
    );

    typedef struct {
        int dig;
        int nib;
        int o;
        int len;
    } slot_t;

    slot_t       expQ[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lastFrameCyc = 0;
    bit          monOn = 1'b0;
    logic [15:0] mShown, mPending;
    logic        mBusy;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic int expO(input logic [15:0] v, input int d);
        bit blank;
        blank = (d != 0) && ((v >> (4 * d)) == 16'h0000);
        return (LZB && blank) ? 0 : 1;
    endfunction

    task automatic pushFrame(input logic [15:0] v, input int nSlots, input int lastLen);
        slot_t s;
        for (int d = 0; d < nSlots; d++) begin
            s.dig = d;
            s.nib = int'((v >> (4 * d)) & 16'h000F);
            s.o   = expO(v, d);
            s.len = (d == nSlots - 1) ? lastLen : P;
            expQ.push_back(s);
        end
    endtask

    task automatic frameEnd();
        if (mBusy) begin
            mShown = mPending;
            mBusy  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v);
        @(negedge Clock);
        Load  = 1'b1;
        Value = v;
        @(negedge Clock);
        Load     = 1'b0;
        mPending = v;
        mBusy    = 1'b1;
        checkOutput($sformatf("busy_after_load_%h", v), Busy, 1);
    endtask

    task automatic waitFrame(input string name);
        int n = 0;
        bit got = 1'b0;
        while (n < 4 * FRAME_LEN && !got) begin
            @(posedge Clock);
            #1;
            n++;
            if (Frame === 1'b1) got = 1'b1;
        end
        checkOutput({name, "_frame_seen"}, got, 1);
        lastFrameCyc = cyc;
        frameEnd();
        checkOutput({name, "_busy_at_frame"}, Busy, mBusy);
    endtask

    // Drives Load so that it is sampled on exactly the frame-end edge.
    task automatic loadOnFrameEnd(input logic [15:0] v);
        int guard = 0;
        while (cyc != lastFrameCyc + FRAME_LEN - 1 && guard < 2 * FRAME_LEN) begin
            @(negedge Clock);
            guard++;
        end
        Load  = 1'b1;
        Value = v;
        @(posedge Clock);
        #1;
        lastFrameCyc = cyc;
        checkOutput($sformatf("frame_on_load_edge_%h", v), Frame, 1);
        frameEnd();
        mPending = v;
        mBusy    = 1'b1;
        checkOutput($sformatf("busy_on_frame_load_%h", v), Busy, 1);
        @(negedge Clock);
        Load = 1'b0;
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_dig_n"}, Dig_n, 4'hF);
        checkOutput({name, "_o"}, O, 0);
        checkOutput({name, "_busy"}, Busy, 0);
        checkOutput({name, "_frame"}, Frame, 0);
        checkOutput({name, "_nibble"}, {Z, Y, X, W}, 0);
    endtask

    task automatic finishSlot(input int dig, input int nib, input int o, input int len);
        slot_t e;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL slot_unexpected actual=digit%0d required=no_slot", dig);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("slot_digit_%0d", e.dig), dig, e.dig);
            checkOutput($sformatf("slot_nibble_d%0d", e.dig), nib, e.nib);
            checkOutput($sformatf("slot_o_d%0d", e.dig), o, e.o);
            checkOutput($sformatf("slot_len_d%0d", e.dig), len, e.len);
        end
    endtask

    // Monitor: turns the Dig_n waveform into lit-slot records and scores them against the queue.
    initial begin
        bit   inSlot = 1'b0;
        int   curDig = 0, curNib = 0, curO = 0, curLen = 0, lastF = -1;
        logic [3:0] prevDig = 4'hF;
        forever begin
            @(posedge Clock);
            #1;
            if (monOn) begin
                checkOutput("one_digit_lit", ($countones(~Dig_n) <= 1) ? 1 : 0, 1);
                if (Enable !== 1'b1 || Resetn !== 1'b1) lastF = -1;
                if (Frame === 1'b1) begin
                    checkOutput("frame_on_digit3", Dig_n, 4'b0111);
                    if (lastF >= 0) checkOutput("frame_period", cyc - lastF, FRAME_LEN);
                    lastF = cyc;
                end
                if (Dig_n !== 4'hF) begin
                    if (!inSlot || Dig_n !== prevDig) begin
                        if (inSlot) finishSlot(curDig, curNib, curO, curLen);
                        inSlot = 1'b1;
                        for (int i = 0; i < 4; i++) if (Dig_n[i] == 1'b0) curDig = i;
                        curNib = int'({Z, Y, X, W});
                        curO   = int'(O);
                        curLen = 1;
                    end else begin
                        curLen++;
                    end
                end else if (inSlot) begin
                    finishSlot(curDig, curNib, curO, curLen);
                    inSlot = 1'b0;
                end
                prevDig = Dig_n;
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        Resetn = 1'b0;
        Enable = 1'b1;
        Load   = 1'b1;
        Value  = 16'hFFFF;
        repeat (2) begin
            @(posedge Clock);
            #1;
            checkReset("reset");
        end
        @(negedge Clock);
        Resetn   = 1'b1;
        Load     = 1'b0;
        Value    = 16'h0000;
        mShown   = 16'h0000;
        mPending = 16'h0000;
        mBusy    = 1'b0;
        pushFrame(16'h0000, 4, P);
        monOn = 1'b1;
        $display("[TB] reset released, scanning");

        waitFrame("f0");
        pushFrame(mShown, 4, P);
        applyStimulus(16'hA3F0);

        waitFrame("f1");
        pushFrame(mShown, 4, P);
        applyStimulus(16'h1234);
        repeat (2) @(negedge Clock);
        applyStimulus(16'h5678);

        waitFrame("f2");
        pushFrame(mShown, 4, P);
        loadOnFrameEnd(16'hC0DE);
        pushFrame(mShown, 4, P);
        applyStimulus(16'h1111);
        loadOnFrameEnd(16'h2222);
        pushFrame(mShown, 4, P);

        waitFrame("f5");
        // Enable drops after digit 2 has been lit for two cycles, so the frame stops there.
        pushFrame(mShown, 3, 2);
        n = 0;
        while (Dig_n !== 4'b1011 && n < 2 * FRAME_LEN) begin
            @(posedge Clock);
            #1;
            n++;
        end
        checkOutput("digit2_seen", Dig_n, 4'b1011);
        @(negedge Clock);
        Enable = 1'b0;
        repeat (2) begin
            @(posedge Clock);
            #1;
        end
        checkOutput("disabled_dig_n", Dig_n, 4'hF);
        checkOutput("disabled_o", O, 0);

        applyStimulus(16'hBEEF);
        @(negedge Clock);
        frameEnd();
        checkOutput("off_transfer_busy", Busy, 0);
        checkOutput("off_dig_n", Dig_n, 4'hF);

        pushFrame(mShown, 4, P);
        @(negedge Clock);
        Enable = 1'b1;
        n = 0;
        while (Dig_n === 4'hF && n < 20) begin
            @(posedge Clock);
            #1;
            n++;
        end
        checkOutput("restart_latency", n, 4);
        checkOutput("restart_digit", Dig_n, 4'b1110);

        waitFrame("f7");
        pushFrame(mShown, 4, P);
        applyStimulus(16'h0040);
        waitFrame("f8");
        pushFrame(mShown, 4, P);
        applyStimulus(16'h0000);
        waitFrame("f9");
        // Reset arrives on the first lit cycle of digit 1 while 7777 is still pending.
        pushFrame(mShown, 2, 1);
        applyStimulus(16'h7777);
        n = 0;
        while (Dig_n !== 4'b1101 && n < 2 * FRAME_LEN) begin
            @(posedge Clock);
            #1;
            n++;
        end
        checkOutput("digit1_seen", Dig_n, 4'b1101);
        @(negedge Clock);
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        checkReset("mid_reset");
        mShown   = 16'h0000;
        mPending = 16'h0000;
        mBusy    = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        pushFrame(16'h0000, 4, P);

        waitFrame("f11");
        @(negedge Clock);
        Enable = 1'b0;
        repeat (4) @(negedge Clock);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
